hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//   Pipeline sequencing controller for the 5-stage ARM core (IF/ID/EX/MEM/WB).
//   Detects load-use hazards, branch-redirect flushes and data-memory wait states.
//   Drives PC enable, IF/ID enable/flush, the control-unit mux select (bubble insert)
//   and EX-stage operand forwarding selects. Keeps saturating stall/flush counters.
// PARAMETERS
//   LOAD_STALL_CYCLES  1   bubbles per load-use hazard (legal 1..3; 2 when no MEM->EX load forward)
//   COUNT_WIDTH        16  width of stall_count / flush_count
// PORTS
//   clk              in   1   system clock, rising edge
//   reset            in   1   asynchronous, active-low reset
//   id_rn, id_rm     in   4   source register numbers of instruction in ID
//   id_use_rn/rm     in   1   ID instruction actually reads rn / rm
//   id_branch_taken  in   1   control unit pc_source_select (branch resolved in ID)
//   ex_rd            in   4   destination register of instruction in EX
//   ex_reg_write     in   1   ID/EX reg_write_enable_out
//   ex_mem_to_reg    in   1   ID/EX mem_to_reg_select_out (instruction in EX is a load)
//   ex_rn, ex_rm     in   4   source registers of instruction in EX
//   mem_rd, wb_rd    in   4   destination registers in MEM / WB
//   mem_reg_write    in   1   EX/MEM reg_write_enable_out
//   wb_reg_write     in   1   MEM/WB reg_write_enable_out
//   mem_busy         in   1   data memory not ready this cycle
//   pc_enable        out  1   program counter load enable
//   if_id_enable     out  1   IF/ID register load enable
//   if_id_flush      out  1   IF/ID loads NOP (32'h0) at next edge
//   cu_mux_select    out  1   1 = zero all control signals into ID/EX (bubble)
//   pipe_hold        out  1   1 = ID/EX, EX/MEM, MEM/WB hold their contents
//   fwd_a, fwd_b     out  2   EX operand select: 00 regfile, 01 WB result, 10 MEM result
//   stall_count      out  COUNT_WIDTH  load-use bubbles inserted
//   flush_count      out  COUNT_WIDTH  branch flushes issued
// BEHAVIOUR
//   - States: RUN, LD_STALL; down-counter ld_cnt (2 bits). Outputs are Mealy (state+inputs).
//   - While reset==0: state=RUN, ld_cnt=0, both counters 0; pc_enable=0, if_id_enable=0,
//     if_id_flush=0, cu_mux_select=1, pipe_hold=0, fwd_a=fwd_b=00. Async assert/release.
//   - load_use = ex_reg_write & ex_mem_to_reg & ex_rd!=15 &
//     ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd)).
//   - Priority each cycle: mem_busy > stall (load_use in RUN, or LD_STALL) > branch > normal.
//   - mem_busy=1 (any state): pc_enable=0, if_id_enable=0, pipe_hold=1, cu_mux_select=0,
//     if_id_flush=0; state, ld_cnt and counters frozen; nothing counted.
//   - RUN & load_use: pc_enable=0, if_id_enable=0, cu_mux_select=1, stall_count+1.
//     If LOAD_STALL_CYCLES>1: next state LD_STALL, ld_cnt=LOAD_STALL_CYCLES-1; else stay RUN.
//   - LD_STALL: same stall outputs, stall_count+1 per cycle, ld_cnt-1; ld_cnt==1 -> RUN.
//     id_branch_taken ignored while stalled (operands not yet valid).
//   - RUN, no load_use, id_branch_taken=1: pc_enable=1, if_id_enable=1, if_id_flush=1,
//     cu_mux_select=0, flush_count+1. Exactly one flush per taken-branch cycle.
//   - Normal: pc_enable=1, if_id_enable=1, if_id_flush=0, cu_mux_select=0, pipe_hold=0.
//   - Forwarding (combinational, state-independent, outputs 00 during reset), per operand X:
//     10 if mem_reg_write & mem_rd==ex_rX & mem_rd!=15; else 01 if wb_reg_write &
//     wb_rd==ex_rX & wb_rd!=15; else 00. MEM beats WB when both match.
//   - Counters saturate at all-ones; no wrap.
//   - Reset asserted mid-LD_STALL: immediate return to RUN, remaining bubbles dropped.
// TESTING
//   1 Reset low 3 cycles -> pc_enable=0, cu_mux_select=1, counters 0; release -> pc_enable=1.
//   2 EX: LDRB r2 (ex_rd=2, load); ID: reads r2 via rn -> 1 cycle pc_enable=0,
//     cu_mux_select=1, stall_count=1; next cycle normal (LOAD_STALL_CYCLES=1).
//   3 Same as 2 with LOAD_STALL_CYCLES=3 -> 3 consecutive stall cycles, stall_count=3.
//   4 id_branch_taken=1 in RUN -> if_id_flush=1 one cycle, flush_count=1; with load_use
//     same cycle -> stall only, flush_count=0.
//   5 mem_rd=wb_rd=ex_rn=5, both writes -> fwd_a=10; mem_reg_write=0 -> 01; rd=15 -> 00.
//   6 mem_busy=1 during LD_STALL for 4 cycles -> pipe_hold=1, ld_cnt/stall_count frozen,
//     stall resumes after mem_busy drops.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls, branch flushes,
// data-memory wait states and EX-stage operand forwarding selects.
module hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [3:0]             i_id_rn,
    input  logic [3:0]             i_id_rm,
    input  logic                   i_id_use_rn,
    input  logic                   i_id_use_rm,
    input  logic                   i_id_branch_taken,
    input  logic [3:0]             i_ex_rd,
    input  logic                   i_ex_reg_write,
    input  logic                   i_ex_mem_to_reg,
    input  logic [3:0]             i_ex_rn,
    input  logic [3:0]             i_ex_rm,
    input  logic [3:0]             i_mem_rd,
    input  logic [3:0]             i_wb_rd,
    input  logic                   i_mem_reg_write,
    input  logic                   i_wb_reg_write,
    input  logic                   i_mem_busy,
    output logic                   o_pc_enable,
    output logic                   o_if_id_enable,
    output logic                   o_if_id_flush,
    output logic                   o_cu_mux_select,
    output logic                   o_pipe_hold,
    output logic [1:0]             o_fwd_a,
    output logic [1:0]             o_fwd_b,
    output logic [COUNT_WIDTH-1:0] o_stall_count,
    output logic [COUNT_WIDTH-1:0] o_flush_count
);

    typedef enum logic {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } state_t;

    localparam bit       MULTI_STALL = (LOAD_STALL_CYCLES > 1);
    localparam logic [1:0] LD_INIT   = 2'(LOAD_STALL_CYCLES - 1);

    state_t                 r_state;
    logic [1:0]             r_ld_cnt;
    logic [COUNT_WIDTH-1:0] r_stall_count;
    logic [COUNT_WIDTH-1:0] r_flush_count;

    logic w_load_use;
    logic w_stall;

    // r15 is the PC, never a forwarded or interlocked register
    assign w_load_use = i_ex_reg_write && i_ex_mem_to_reg && (i_ex_rd != 4'd15) &&
                        ((i_id_use_rn && (i_id_rn == i_ex_rd)) ||
                         (i_id_use_rm && (i_id_rm == i_ex_rd)));

    assign w_stall = (r_state == LD_STALL) || w_load_use;

    always_comb begin
        o_pc_enable     = 1'b1;
        o_if_id_enable  = 1'b1;
        o_if_id_flush   = 1'b0;
        o_cu_mux_select = 1'b0;
        o_pipe_hold     = 1'b0;
        if (!i_reset) begin
            o_pc_enable     = 1'b0;
            o_if_id_enable  = 1'b0;
            o_cu_mux_select = 1'b1;
        end else if (i_mem_busy) begin
            o_pc_enable     = 1'b0;
            o_if_id_enable  = 1'b0;
            o_pipe_hold     = 1'b1;
        end else if (w_stall) begin
            o_pc_enable     = 1'b0;
            o_if_id_enable  = 1'b0;
            o_cu_mux_select = 1'b1;
        end else if (i_id_branch_taken) begin
            o_if_id_flush   = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       mem_w,
        input logic [3:0] mem_rd,
        input logic       wb_w,
        input logic [3:0] wb_rd
    );
        if (mem_w && (mem_rd == src) && (mem_rd != 4'd15))
            return 2'b10;
        else if (wb_w && (wb_rd == src) && (wb_rd != 4'd15))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        o_fwd_a = 2'b00;
        o_fwd_b = 2'b00;
        if (i_reset) begin
            o_fwd_a = fwd_sel(i_ex_rn, i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);
            o_fwd_b = fwd_sel(i_ex_rm, i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= RUN;
            r_ld_cnt      <= 2'd0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (!i_mem_busy) begin
            if (w_stall) begin
                if (r_stall_count != '1)
                    r_stall_count <= r_stall_count + 1'b1;
                if (r_state == LD_STALL) begin
                    r_ld_cnt <= r_ld_cnt - 2'd1;
                    if (r_ld_cnt == 2'd1)
                        r_state <= RUN;
                end else if (MULTI_STALL) begin
                    r_state  <= LD_STALL;
                    r_ld_cnt <= LD_INIT;
                end
            end else if (i_id_branch_taken) begin
                if (r_flush_count != '1)
                    r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: three instances (1-bubble, 3-bubble,
// 2-bit counters) share stimulus; expected records flow through a scoreboard queue.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] id_rn, id_rm, ex_rd, ex_rn, ex_rm, mem_rd, wb_rd;
    logic       id_use_rn, id_use_rm, id_branch_taken;
    logic       ex_reg_write, ex_mem_to_reg, mem_reg_write, wb_reg_write, mem_busy;

    logic       pc_en [3];
    logic       ifid_en [3];
    logic       flush [3];
    logic       cu_sel [3];
    logic       hold [3];
    logic [1:0] fwd_a [3];
    logic [1:0] fwd_b [3];
    logic [15:0] sc1, fc1, sc3, fc3;
    logic [1:0]  scs, fcs;

    always #5 clk = ~clk;

    hazard_controller #(.LOAD_STALL_CYCLES(1), .COUNT_WIDTH(16)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_id_rn(id_rn), .i_id_rm(id_rm),
        .i_id_use_rn(id_use_rn), .i_id_use_rm(id_use_rm), .i_id_branch_taken(id_branch_taken),
        .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write), .i_ex_mem_to_reg(ex_mem_to_reg),
        .i_ex_rn(ex_rn), .i_ex_rm(ex_rm), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
        .i_mem_reg_write(mem_reg_write), .i_wb_reg_write(wb_reg_write), .i_mem_busy(mem_busy),
        .o_pc_enable(pc_en[0]), .o_if_id_enable(ifid_en[0]), .o_if_id_flush(flush[0]),
        .o_cu_mux_select(cu_sel[0]), .o_pipe_hold(hold[0]), .o_fwd_a(fwd_a[0]),
        .o_fwd_b(fwd_b[0]), .o_stall_count(sc1), .o_flush_count(fc1));

    hazard_controller #(.LOAD_STALL_CYCLES(3), .COUNT_WIDTH(16)) dut3 (
        .i_clk(clk), .i_reset(reset), .i_id_rn(id_rn), .i_id_rm(id_rm),
        .i_id_use_rn(id_use_rn), .i_id_use_rm(id_use_rm), .i_id_branch_taken(id_branch_taken),
        .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write), .i_ex_mem_to_reg(ex_mem_to_reg),
        .i_ex_rn(ex_rn), .i_ex_rm(ex_rm), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
        .i_mem_reg_write(mem_reg_write), .i_wb_reg_write(wb_reg_write), .i_mem_busy(mem_busy),
        .o_pc_enable(pc_en[1]), .o_if_id_enable(ifid_en[1]), .o_if_id_flush(flush[1]),
        .o_cu_mux_select(cu_sel[1]), .o_pipe_hold(hold[1]), .o_fwd_a(fwd_a[1]),
        .o_fwd_b(fwd_b[1]), .o_stall_count(sc3), .o_flush_count(fc3));

    hazard_controller #(.LOAD_STALL_CYCLES(1), .COUNT_WIDTH(2)) dut_sat (
        .i_clk(clk), .i_reset(reset), .i_id_rn(id_rn), .i_id_rm(id_rm),
        .i_id_use_rn(id_use_rn), .i_id_use_rm(id_use_rm), .i_id_branch_taken(id_branch_taken),
        .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write), .i_ex_mem_to_reg(ex_mem_to_reg),
        .i_ex_rn(ex_rn), .i_ex_rm(ex_rm), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
        .i_mem_reg_write(mem_reg_write), .i_wb_reg_write(wb_reg_write), .i_mem_busy(mem_busy),
        .o_pc_enable(pc_en[2]), .o_if_id_enable(ifid_en[2]), .o_if_id_flush(flush[2]),
        .o_cu_mux_select(cu_sel[2]), .o_pipe_hold(hold[2]), .o_fwd_a(fwd_a[2]),
        .o_fwd_b(fwd_b[2]), .o_stall_count(scs), .o_flush_count(fcs));

    // hit: 0 none, 1 ID reads ex_rd via rn, 2 via rm, 3 rm equals ex_rd but is not read
    typedef struct {
        int         sel;
        logic       rst;
        logic       ld;
        logic [3:0] rd;
        int         hit;
        logic       br;
        logic       busy;
        logic       mw;
        logic [3:0] mrd;
        logic       ww;
        logic [3:0] wrd;
        logic [3:0] xrn;
        logic [3:0] xrm;
        logic       pc, ifid, fl, cu, hd;
        logic [1:0] fa, fb;
        int         sc, fc;
    } vec_t;

    vec_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_vec    = 0;

    function automatic vec_t mk(input int sel, input logic rst, input logic ld,
                                input logic [3:0] rd, input int hit, input logic br,
                                input logic busy, input logic pc, input logic ifid,
                                input logic fl, input logic cu, input logic hd,
                                input int sc, input int fc);
        vec_t x;
        x.sel = sel; x.rst = rst; x.ld = ld; x.rd = rd; x.hit = hit; x.br = br; x.busy = busy;
        x.mw = 1'b0; x.mrd = 4'd0; x.ww = 1'b0; x.wrd = 4'd0; x.xrn = 4'd1; x.xrm = 4'd2;
        x.pc = pc; x.ifid = ifid; x.fl = fl; x.cu = cu; x.hd = hd;
        x.fa = 2'b00; x.fb = 2'b00; x.sc = sc; x.fc = fc;
        return x;
    endfunction

    function automatic vec_t mkf(input logic mw, input logic [3:0] mrd, input logic ww,
                                 input logic [3:0] wrd, input logic [3:0] xrn,
                                 input logic [3:0] xrm, input logic [1:0] fa, input logic [1:0] fb);
        vec_t x;
        x = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        x.mw = mw; x.mrd = mrd; x.ww = ww; x.wrd = wrd; x.xrn = xrn; x.xrm = xrm;
        x.fa = fa; x.fb = fb;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        @(posedge clk);
        #1;
        reset           = x.rst;
        ex_reg_write    = x.ld;
        ex_mem_to_reg   = x.ld;
        ex_rd           = x.rd;
        id_use_rn       = (x.hit == 1);
        id_use_rm       = (x.hit == 2);
        id_rn           = (x.hit == 1) ? x.rd : 4'd9;
        id_rm           = (x.hit >= 2) ? x.rd : 4'd11;
        id_branch_taken = x.br;
        mem_busy        = x.busy;
        mem_reg_write   = x.mw;
        mem_rd          = x.mrd;
        wb_reg_write    = x.ww;
        wb_rd           = x.wrd;
        ex_rn           = x.xrn;
        ex_rm           = x.xrm;
        sb.push_back(x);
    endtask

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            vec_t e;
            int   s, a_sc, a_fc;
            e = sb.pop_front();
            s = e.sel;
            case (s)
                0:       begin a_sc = int'(sc1); a_fc = int'(fc1); end
                1:       begin a_sc = int'(sc3); a_fc = int'(fc3); end
                default: begin a_sc = int'(scs); a_fc = int'(fcs); end
            endcase
            chk("pc_enable",     n_vec, int'(pc_en[s]),   int'(e.pc));
            chk("if_id_enable",  n_vec, int'(ifid_en[s]), int'(e.ifid));
            chk("if_id_flush",   n_vec, int'(flush[s]),   int'(e.fl));
            chk("cu_mux_select", n_vec, int'(cu_sel[s]),  int'(e.cu));
            chk("pipe_hold",     n_vec, int'(hold[s]),    int'(e.hd));
            chk("fwd_a",         n_vec, int'(fwd_a[s]),   int'(e.fa));
            chk("fwd_b",         n_vec, int'(fwd_b[s]),   int'(e.fb));
            chk("stall_count",   n_vec, a_sc,             e.sc);
            chk("flush_count",   n_vec, a_fc,             e.fc);
            n_vec++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t x;
        reset = 1'b0; id_rn = 0; id_rm = 0; ex_rd = 0; ex_rn = 0; ex_rm = 0;
        mem_rd = 0; wb_rd = 0; id_use_rn = 0; id_use_rm = 0; id_branch_taken = 0;
        ex_reg_write = 0; ex_mem_to_reg = 0; mem_reg_write = 0; wb_reg_write = 0; mem_busy = 0;

        // sel rst ld rd hit br busy | pc ifid fl cu hold | sc fc   (1-bubble instance)
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0, 1, 0, 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 4,  2, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 1, 15, 1, 0, 0, 1, 1, 0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 1, 2,  1, 0, 1, 0, 0, 0, 0, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 1, 2, 1));
        tbl.push_back(mk(0, 1, 1, 3,  3, 0, 0, 1, 1, 0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0,  0, 1, 0, 1, 1, 1, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0,  0, 1, 0, 1, 1, 1, 0, 0, 2, 2));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 2, 3));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        foreach (tbl[i]) drive(tbl[i]);

        // 3-bubble load-use, branch ignored while stalled
        drive(mk(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        drive(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0));
        drive(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 0));
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3, 0));
        // memory wait in the middle of LD_STALL freezes the bubble count
        drive(mk(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 3, 0));
        for (int i = 0; i < 4; i++)
            drive(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0));
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0));
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0));
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 6, 0));
        // reset in LD_STALL drops the remaining bubbles
        drive(mk(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 6, 0));
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        drive(mk(1, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0));
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));

        // 2-bit counters saturate at 3
        drive(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            drive(mk(2, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, (i > 3) ? 3 : i, 0));
        for (int i = 0; i < 5; i++)
            drive(mk(2, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 3, (i > 3) ? 3 : i));
        drive(mk(2, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3, 3));

        // forwarding: select held at 00 during reset even with a match
        x = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        x.mw = 1'b1; x.mrd = 4'd5; x.xrn = 4'd5;
        drive(x);
        drive(mkf(1, 5,  1, 5,  5,  3,  2'b10, 2'b00));
        drive(mkf(0, 5,  1, 5,  5,  5,  2'b01, 2'b01));
        drive(mkf(1, 15, 1, 15, 15, 15, 2'b00, 2'b00));
        drive(mkf(1, 15, 1, 4,  15, 4,  2'b00, 2'b01));
        drive(mkf(1, 6,  0, 6,  1,  6,  2'b00, 2'b10));
        drive(mkf(0, 6,  0, 6,  6,  6,  2'b00, 2'b00));
        drive(mkf(1, 7,  1, 8,  8,  7,  2'b01, 2'b10));

        @(negedge clk);
        @(negedge clk);
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
